// File: rtl/uart_loader_if.sv
// Program-memory write bus and status lines of the UART image loader.
// The loader owns every signal here; the core/memory side only observes.
interface uart_loader_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        core_run;
    logic        err;
    logic [15:0] words_left;

    modport master (
        output mem_addr,
        output mem_data,
        output mem_we,
        output core_run,
        output err,
        output words_left
    );

    modport slave (
        input mem_addr,
        input mem_data,
        input mem_we,
        input core_run,
        input err,
        input words_left
    );
endinterface

// File: rtl/uart_loader.sv
// UART 8N1 boot loader: length header, then little-endian words
// written to program memory; releases the core when the image is in.
module uart_loader #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    uart_loader_if.master mem
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLK_DIV / 2) - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        LD_LEN_LO,
        LD_LEN_HI,
        LD_DATA,
        LD_DONE,
        LD_ERROR
    } ld_state_t;

    rx_state_t   rx_state;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
    logic        byte_valid;
    logic        frame_err;

    ld_state_t   ld_state;
    logic [7:0]  len_lo;
    logic [23:0] word_q;
    logic [1:0]  byte_cnt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        we_q;
    logic        run_q;
    logic        err_q;
    logic [15:0] left_q;

    assign mem.mem_addr   = addr_q;
    assign mem.mem_data   = data_q;
    assign mem.mem_we     = we_q;
    assign mem.core_run   = run_q;
    assign mem.err        = err_q;
    assign mem.words_left = left_q;

    // Receiver: start edge detected on the synchronized line, then
    // mid-bit sampling driven by a single baud counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        baud_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == DIV_LAST) begin
                        baud_cnt <= '0;
                        shift_q  <= {rx_sync, shift_q[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == DIV_LAST) begin
                        baud_cnt <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Loader: words_left drops together with the write strobe so the
    // final write is recognised in its own strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state <= LD_LEN_LO;
            len_lo   <= '0;
            word_q   <= '0;
            byte_cnt <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            run_q    <= 1'b0;
            err_q    <= 1'b0;
            left_q   <= '0;
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                addr_q <= addr_q + 32'd1;
            end
            unique case (ld_state)
                LD_LEN_LO: begin
                    if (frame_err) begin
                        ld_state <= LD_ERROR;
                        err_q    <= 1'b1;
                    end else if (byte_valid) begin
                        len_lo   <= shift_q;
                        ld_state <= LD_LEN_HI;
                    end
                end
                LD_LEN_HI: begin
                    if (frame_err) begin
                        ld_state <= LD_ERROR;
                        err_q    <= 1'b1;
                    end else if (byte_valid) begin
                        left_q   <= {shift_q, len_lo};
                        byte_cnt <= '0;
                        if ({shift_q, len_lo} == 16'd0) begin
                            ld_state <= LD_DONE;
                            run_q    <= 1'b1;
                        end else begin
                            ld_state <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (we_q && left_q == 16'd0) begin
                        ld_state <= LD_DONE;
                        run_q    <= 1'b1;
                    end else if (frame_err) begin
                        ld_state <= LD_ERROR;
                        err_q    <= 1'b1;
                        run_q    <= 1'b0;
                        byte_cnt <= '0;
                    end else if (byte_valid) begin
                        if (byte_cnt == 2'd3) begin
                            data_q   <= {shift_q, word_q};
                            we_q     <= 1'b1;
                            left_q   <= left_q - 16'd1;
                            byte_cnt <= '0;
                        end else begin
                            word_q[{byte_cnt, 3'b000} +: 8] <= shift_q;
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                LD_DONE: begin
                    ld_state <= LD_DONE;
                end
                LD_ERROR: begin
                    ld_state <= LD_ERROR;
                end
                default: begin
                    ld_state <= LD_ERROR;
                    err_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: UART frames in, expected writes
// queued by the stimulus and consumed by an independent monitor.
module tb_uart_loader;

    localparam int DIV = 16;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] left;
        logic        last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    uart_loader_if bus ();

    uart_loader #(.CLK_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .mem   (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk) rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d,
                                input logic [15:0] l, input logic last);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.left = l;
        e.last = last;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        chk(name, q.size(), 0);
    endtask

    // Reset lands between clock edges; outputs are checked before any edge.
    task automatic do_reset(input string name);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({name, "_addr"}, bus.mem_addr, 32'h0);
        chk({name, "_data"}, bus.mem_data, 32'h0);
        chk({name, "_we"}, {31'h0, bus.mem_we}, 32'h0);
        chk({name, "_run"}, {31'h0, bus.core_run}, 32'h0);
        chk({name, "_err"}, {31'h0, bus.err}, 32'h0);
        chk({name, "_left"}, {16'h0, bus.words_left}, 32'h0);
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_we) begin
                chk("we_and_run", {31'h0, bus.core_run}, 32'h0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_we: addr %h data %h",
                             bus.mem_addr, bus.mem_data);
                end else begin
                    e = q.pop_front();
                    chk("wr_addr", bus.mem_addr, e.addr);
                    chk("wr_data", bus.mem_data, e.data);
                    chk("wr_left", {16'h0, bus.words_left}, {16'h0, e.left});
                    if (e.last) begin
                        @(negedge clk);
                        chk("run_after_last", {31'h0, bus.core_run}, 32'h1);
                        chk("we_after_last", {31'h0, bus.mem_we}, 32'h0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #3;
        chk("por_addr", bus.mem_addr, 32'h0);
        chk("por_we", {31'h0, bus.mem_we}, 32'h0);
        chk("por_run", {31'h0, bus.core_run}, 32'h0);
        chk("por_left", {16'h0, bus.words_left}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Two-word image
        send_byte(8'h02);
        send_byte(8'h00);
        chk("hdr_left", {16'h0, bus.words_left}, 32'h2);
        expect_write(32'd0, 32'h12345678, 16'd1, 1'b0);
        expect_write(32'd1, 32'hDEADBEEF, 16'd0, 1'b1);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        drain("img2_drain");
        chk("img2_run", {31'h0, bus.core_run}, 32'h1);
        chk("img2_addr", bus.mem_addr, 32'd2);

        // Traffic after completion, including a bad stop bit
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h33, 1'b0);
        chk("done_addr", bus.mem_addr, 32'd2);
        chk("done_left", {16'h0, bus.words_left}, 32'h0);
        chk("done_run", {31'h0, bus.core_run}, 32'h1);
        chk("done_err", {31'h0, bus.err}, 32'h0);

        // Zero-length image
        do_reset("rst1");
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (4) @(negedge clk);
        chk("zero_run", {31'h0, bus.core_run}, 32'h1);
        chk("zero_left", {16'h0, bus.words_left}, 32'h0);
        chk("zero_addr", bus.mem_addr, 32'h0);

        // Short low glitch, then a one-word image
        do_reset("rst2");
        @(negedge clk) rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        chk("glitch_err", {31'h0, bus.err}, 32'h0);
        chk("glitch_left", {16'h0, bus.words_left}, 32'h0);
        expect_write(32'd0, 32'h04030201, 16'd0, 1'b1);
        send_byte(8'h01);
        send_byte(8'h00);
        chk("glitch_hdr", {16'h0, bus.words_left}, 32'h1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        drain("glitch_drain");
        chk("glitch_run", {31'h0, bus.core_run}, 32'h1);

        // Framing error mid-word
        do_reset("rst3");
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'h55, 1'b0);
        chk("ferr_err", {31'h0, bus.err}, 32'h1);
        chk("ferr_run", {31'h0, bus.core_run}, 32'h0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("ferr_err2", {31'h0, bus.err}, 32'h1);
        chk("ferr_run2", {31'h0, bus.core_run}, 32'h0);
        chk("ferr_left", {16'h0, bus.words_left}, 32'h1);
        chk("ferr_addr", bus.mem_addr, 32'h0);

        // Reset mid-word drops the partial image
        do_reset("rst4");
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset("rst5");
        expect_write(32'd0, 32'h11223344, 16'd0, 1'b1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h44);
        send_byte(8'h33);
        send_byte(8'h22);
        send_byte(8'h11);
        drain("rst_drain");
        chk("rst_run", {31'h0, bus.core_run}, 32'h1);
        chk("rst_addr", bus.mem_addr, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
